// File: rtl/stdp_pkg.sv
// Shared types and helpers for the RNL neuron column: FSM state encoding,
// default neuron constants and a saturating adder.
package stdp_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INTEGRATE = 2'd1,
    FINISH    = 2'd2
  } rnl_state_t;

  localparam int DEF_NUM_INPUTS  = 16;
  localparam int DEF_WEIGHT_W    = 3;
  localparam int DEF_TIME_PERIOD = 8;
  localparam int DEF_THRESHOLD   = 24;

  // Clamp the sum to max so the body potential can never wrap back below threshold.
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max);
    int unsigned sum;
    sum = a + b;
    return (sum > max) ? max : sum;
  endfunction

endpackage : stdp_pkg

// File: rtl/rnl_neuron_gamma_weighted_spike_sum.sv
// Combinational masked sum: adds the weight of every synapse whose step spike
// is already high, producing the per-cycle potential increment.
module weighted_spike_sum
  import stdp_pkg::*;
#(
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int WEIGHT_W   = DEF_WEIGHT_W,
  parameter int INC_W      = $clog2(NUM_INPUTS * (2**WEIGHT_W - 1) + 1)
) (
  input  logic [NUM_INPUTS*WEIGHT_W-1:0] i_weights,
  input  logic [NUM_INPUTS-1:0]          i_spike_in,
  output logic [INC_W-1:0]               o_inc
);

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    o_inc = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (i_spike_in[i]) begin
        o_inc = o_inc + INC_W'(i_weights[i*WEIGHT_W +: WEIGHT_W]);
      end
    end
  end

endmodule : weighted_spike_sum

// File: rtl/rnl_neuron_gamma.sv
// Ramp-no-leak neuron with gamma-cycle step counter. Optional lateral
// inhibition input is enabled by defining RNL_WTA_INHIBIT_EN.
`ifndef LOG_TIME_PERIOD
`define LOG_TIME_PERIOD 3
`endif

module rnl_neuron_gamma
  import stdp_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int WEIGHT_W    = DEF_WEIGHT_W,
  parameter int TIME_PERIOD = 2**`LOG_TIME_PERIOD,
  parameter int THRESHOLD   = DEF_THRESHOLD
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic                           start,
  input  logic [NUM_INPUTS*WEIGHT_W-1:0] weights,
  input  logic [NUM_INPUTS-1:0]          spike_in,
`ifdef RNL_WTA_INHIBIT_EN
  input  logic                           inhibit_in,
`endif
  output logic [`LOG_TIME_PERIOD:0]      time_val,
  output logic                           busy,
  output logic                           spike_out,
  output logic [`LOG_TIME_PERIOD:0]      out_time,
  output logic                           done
);

  localparam int          TW      = `LOG_TIME_PERIOD + 1;
  localparam int          INC_W   = $clog2(NUM_INPUTS * (2**WEIGHT_W - 1) + 1);
  localparam int          POT_W   = $clog2(THRESHOLD + 1) + 1;
  localparam int unsigned POT_MAX = (32'd1 << POT_W) - 32'd1;

  rnl_state_t       r_state;
  logic [TW-1:0]    r_time_val;
  logic [POT_W-1:0] r_potential;
  logic             r_busy;
  logic             r_spike_out;
  logic [TW-1:0]    r_out_time;
  logic             r_done;
`ifdef RNL_WTA_INHIBIT_EN
  logic             r_inhibited;
`endif

  logic [INC_W-1:0] w_inc;
  logic [POT_W-1:0] w_pot_next;
  logic             w_last_step;
  logic             w_fire;

  weighted_spike_sum #(
    .NUM_INPUTS (NUM_INPUTS),
    .WEIGHT_W   (WEIGHT_W),
    .INC_W      (INC_W)
  ) u_sum (
    .i_weights  (weights),
    .i_spike_in (spike_in),
    .o_inc      (w_inc)
  );

  assign w_pot_next  = POT_W'(sat_add(32'(r_potential), 32'(w_inc), POT_MAX));
  assign w_last_step = (r_time_val == TW'(TIME_PERIOD - 1));

  // Fire decision uses the potential including this step's increment, so a
  // spike seen at step t shows on spike_out right after that edge.
`ifdef RNL_WTA_INHIBIT_EN
  assign w_fire = (r_state == INTEGRATE) && !r_spike_out && !r_inhibited && !inhibit_in &&
                  (w_pot_next >= POT_W'(THRESHOLD));
`else
  assign w_fire = (r_state == INTEGRATE) && !r_spike_out &&
                  (w_pot_next >= POT_W'(THRESHOLD));
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state     <= IDLE;
      r_time_val  <= '0;
      r_potential <= '0;
      r_busy      <= 1'b0;
      r_spike_out <= 1'b0;
      r_out_time  <= TW'(TIME_PERIOD);
      r_done      <= 1'b0;
`ifdef RNL_WTA_INHIBIT_EN
      r_inhibited <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state     <= INTEGRATE;
            r_time_val  <= '0;
            r_potential <= '0;
            r_busy      <= 1'b1;
            r_spike_out <= 1'b0;
            r_out_time  <= TW'(TIME_PERIOD);
`ifdef RNL_WTA_INHIBIT_EN
            r_inhibited <= 1'b0;
`endif
          end
        end

        INTEGRATE: begin
          r_potential <= w_pot_next;
          if (w_last_step) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
          end else begin
            r_time_val <= r_time_val + TW'(1);
          end
          if (w_fire) begin
            r_spike_out <= 1'b1;
            r_out_time  <= r_time_val;
          end
`ifdef RNL_WTA_INHIBIT_EN
          // Only inhibition arriving before the fire matters; afterwards the result stands.
          if (inhibit_in && !r_spike_out) begin
            r_inhibited <= 1'b1;
          end
`endif
        end

        FINISH: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign time_val  = r_time_val;
  assign busy      = r_busy;
  assign spike_out = r_spike_out;
  assign out_time  = r_out_time;
  assign done      = r_done;

endmodule : rnl_neuron_gamma

// File: tb/tb_rnl_neuron_gamma.sv
// Self-checking bench for rnl_neuron_gamma: randomized gamma cycles against a
// step-by-step arithmetic model, plus directed boundary and reset cases.
`ifndef LOG_TIME_PERIOD
`define LOG_TIME_PERIOD 3
`endif

module tb_rnl_neuron_gamma;

  localparam int NI      = 16;
  localparam int WW      = 3;
  localparam int TP      = 2**`LOG_TIME_PERIOD;
  localparam int THR     = 24;
  localparam int TW      = `LOG_TIME_PERIOD + 1;
  localparam int POT_MAX = (1 << ($clog2(THR + 1) + 1)) - 1;

  logic           clk = 1'b0;
  logic           rst_l = 1'b0;
  logic           start = 1'b0;
  logic [NI*WW-1:0] weights = '0;
  logic [NI-1:0]  spike_in = '0;
  logic           inhibit_in = 1'b0;

  logic [TW-1:0]  time_val, out_time, z_time_val, z_out_time;
  logic           busy, spike_out, done, z_busy, z_spike_out, z_done;

  int n_tests = 0;
  int n_fail  = 0;

  int sp_step[NI];
  int wt[NI];

  always #5 clk = ~clk;

  rnl_neuron_gamma #(.NUM_INPUTS(NI), .WEIGHT_W(WW), .TIME_PERIOD(TP), .THRESHOLD(THR)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .start     (start),
    .weights   (weights),
    .spike_in  (spike_in),
`ifdef RNL_WTA_INHIBIT_EN
    .inhibit_in(inhibit_in),
`endif
    .time_val  (time_val),
    .busy      (busy),
    .spike_out (spike_out),
    .out_time  (out_time),
    .done      (done)
  );

  // Zero-threshold instance sharing the same stimulus: must fire at step 0 every cycle.
  rnl_neuron_gamma #(.NUM_INPUTS(NI), .WEIGHT_W(WW), .TIME_PERIOD(TP), .THRESHOLD(0)) dut_z (
    .clk       (clk),
    .rst_l     (rst_l),
    .start     (start),
    .weights   (weights),
    .spike_in  (spike_in),
`ifdef RNL_WTA_INHIBIT_EN
    .inhibit_in(1'b0),
`endif
    .time_val  (z_time_val),
    .busy      (z_busy),
    .spike_out (z_spike_out),
    .out_time  (z_out_time),
    .done      (z_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: walk the gamma cycle step by step with plain integers.
  function automatic int model_fire(input int inh_step);
    int  pot;
    int  fired;
    bit  inh;
    pot   = 0;
    fired = -1;
    inh   = 1'b0;
    for (int t = 0; t < TP; t++) begin
      int inc;
      inc = 0;
      for (int i = 0; i < NI; i++) if (t >= sp_step[i]) inc += wt[i];
      pot = (pot + inc > POT_MAX) ? POT_MAX : pot + inc;
`ifdef RNL_WTA_INHIBIT_EN
      if (t == inh_step && fired < 0) inh = 1'b1;
`else
      if (inh_step > TP) inh = 1'b0;
`endif
      if (fired < 0 && !inh && pot >= THR) fired = t;
    end
    return (fired < 0) ? TP : fired;
  endfunction

  task automatic drive_step(input int t);
    for (int i = 0; i < NI; i++) spike_in[i] = (t >= sp_step[i]);
  endtask

  task automatic load_weights();
    for (int i = 0; i < NI; i++) weights[i*WW +: WW] = WW'(wt[i]);
  endtask

  task automatic run_cycle(input string name, input int inh_step, input bit poke_start);
    int exp_fire;
    exp_fire = model_fire(inh_step);
    load_weights();
    spike_in = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, ".t0"},      time_val,  0);
    check({name, ".busy0"},   busy,      1);
    check({name, ".spk0"},    spike_out, 0);
    check({name, ".otime0"},  out_time,  TP);
    for (int t = 0; t < TP; t++) begin
      drive_step(t);
      inhibit_in = (t == inh_step);
      if (poke_start && t == 3) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      inhibit_in = 1'b0;
      check({name, ".spk"},  spike_out, (exp_fire <= t) ? 1 : 0);
      check({name, ".tval"}, time_val,  (t < TP - 1) ? t + 1 : TP - 1);
      check({name, ".done"}, done,      (t == TP - 1) ? 1 : 0);
      if (t == 0) begin
        check({name, ".z_spk"},   z_spike_out, 1);
        check({name, ".z_otime"}, z_out_time,  0);
      end
    end
    check({name, ".otime"},  out_time, exp_fire);
    check({name, ".busyF"},  busy,     1);
    if (poke_start) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, ".doneX"},  done,      0);
    check({name, ".busyX"},  busy,      0);
    check({name, ".otimeX"}, out_time,  exp_fire);
    check({name, ".spkX"},   spike_out, (exp_fire < TP) ? 1 : 0);
    @(posedge clk); #1;
    check({name, ".idle"},   busy,      0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, ".tval"},  time_val,  0);
    check({name, ".busy"},  busy,      0);
    check({name, ".spk"},   spike_out, 0);
    check({name, ".otime"}, out_time,  TP);
    check({name, ".done"},  done,      0);
  endtask

  task automatic set_all(input int step, input int w);
    for (int i = 0; i < NI; i++) begin
      sp_step[i] = step;
      wt[i]      = w;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_l = 1'b1;

    // No spikes at all.
    set_all(TP, 7);
    run_cycle("nospike", -1, 1'b0);

    // One synapse, weight 7, from step 0: 7,14,21,28 -> fires at step 3.
    set_all(TP, 0);
    sp_step[0] = 0; wt[0] = 7;
    for (int i = 1; i < NI; i++) sp_step[i] = 0;
    run_cycle("single", -1, 1'b0);
    check("single.model", model_fire(-1), 3);

    // Weight 3 reaches exactly 24 on the last step.
    set_all(TP, 0);
    sp_step[0] = 0; wt[0] = 3;
    run_cycle("laststep", -1, 1'b0);

    // All inputs, weight 7, at step 0: increment 112, potential saturates.
    set_all(0, 7);
    run_cycle("allin", -1, 1'b0);

    // Reset at step 4 of an active cycle.
    set_all(TP, 0);
    sp_step[0] = 0; wt[0] = 7;
    load_weights();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      drive_step(t);
      @(posedge clk); #1;
    end
    rst_l = 1'b0;
    @(posedge clk); #1;
    check_reset_values("midrst");
    rst_l = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("midrst.nodone", done, 0);
    end
    run_cycle("afterrst", -1, 1'b0);

    // Start pokes during INTEGRATE and FINISH are ignored.
    for (int i = 0; i < NI; i++) begin
      sp_step[i] = $urandom_range(0, TP);
      wt[i]      = $urandom_range(0, 3);
    end
    run_cycle("poke", -1, 1'b1);

    // Randomized cycles.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NI; i++) begin
        int s;
        s = $urandom_range(0, 3 * TP);
        sp_step[i] = (s > TP) ? TP : s;
        wt[i]      = $urandom_range(0, 2**WW - 1);
      end
      run_cycle("rand", -1, $urandom_range(0, 1) == 1);
    end

`ifdef RNL_WTA_INHIBIT_EN
    set_all(TP, 0);
    sp_step[0] = 0; wt[0] = 7;
    run_cycle("inh_early", 2, 1'b0);
    check("inh_early.model", model_fire(2), TP);
    run_cycle("inh_fire", 3, 1'b0);
    run_cycle("inh_late", 5, 1'b0);
    check("inh_late.model", model_fire(5), 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rnl_neuron_gamma
